fft_seq_ctrl: RTL and testbench

- Parametrised single-clock successor to the 64-point FFT controller.
- Sequences an in-place radix-2 DIT FFT of N = 2**LOG2N points over two ping-pong RAM banks and an external butterfly unit.
- Owns load (bit-reversed write), compute (stage/butterfly issue with pipeline delay and inter-stage flush), and drain (natural-order valid/ready output).
- No derived clocks; RAM, twiddle ROM and butterfly are instantiated outside.

---
 rtl/fft_seq_pkg.sv | 24 ++
 rtl/fft_seq_agu.sv | 33 +++
 rtl/fft_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT sequencer.
// The optional inverse transform is enabled with FFT_IFFT_EN.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FLUSH,
    DRAIN
  } state_t;

  function automatic int pipe_len(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction

  // Reverses the low n bits of x (n <= 12).
  function automatic logic [11:0] bitrev(input logic [11:0] x,
                                         input int n);
    logic [11:0] r;
    r = {<<{x}};
    return r >> (12 - n);
  endfunction

endpackage

// File: rtl/fft_seq_agu.sv
// Butterfly address generator: (stage, index) to RAM pair and twiddle.
// Purely combinational; FFT_IFFT_EN does not affect this block.
module fft_seq_agu
  import fft_seq_pkg::*;
#(
  parameter int LOG2N = 6
) (
  input  logic [3:0]       i_s,
  input  logic [LOG2N-2:0] i_j,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [LOG2N-2:0] o_tw
);

  localparam int AW = LOG2N;
  localparam int JW = LOG2N - 1;

  logic [AW-1:0] w_j;
  logic [AW-1:0] w_half;
  logic [AW-1:0] w_k;
  logic [AW-1:0] w_a;

  always_comb begin
    w_j      = AW'(i_j);
    w_half   = AW'(1) << i_s;
    w_k      = w_j & (w_half - AW'(1));
    w_a      = ((w_j >> i_s) << (i_s + 4'd1)) + w_k;
    o_addr_a = w_a;
    o_addr_b = w_a + w_half;
    o_tw     = JW'(w_k << (4'(AW - 1) - i_s));
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Load / compute / drain sequencer for an in-place N-point radix-2 FFT.
// Define FFT_IFFT_EN to add the inverse-transform control ports.
module fft_seq_ctrl
  import fft_seq_pkg::*;
#(
  parameter int LOG2N  = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [DW-1:0]    load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             rd_bank,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  input  logic [DW-1:0]    rd_data_a,
  input  logic [DW-1:0]    rd_data_b,
  output logic [LOG2N-2:0] tw_addr,
  input  logic [DW-1:0]    bf_a_out,
  input  logic [DW-1:0]    bf_b_out,
  output logic             wr_bank,
  output logic             wr_en_a,
  output logic             wr_en_b,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [DW-1:0]    wr_data_a,
  output logic [DW-1:0]    wr_data_b
`ifdef FFT_IFFT_EN
  ,
  input  logic             inverse,
  output logic             twiddle_conj,
  output logic             scale_shift
`endif
);

  localparam int N    = 1 << LOG2N;
  localparam int AW   = LOG2N;
  localparam int JW   = LOG2N - 1;
  localparam int CW   = 16;
  localparam int PIPE = pipe_len(RD_LAT, BF_LAT);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic [3:0]    r_s;
  logic [JW-1:0] r_j;
  logic [CW-1:0] r_fc;
  logic [AW-1:0] r_i;
  logic [CW-1:0] r_dw;

  logic          r_dv [PIPE];
  logic [AW-1:0] r_da [PIPE];
  logic [AW-1:0] r_db [PIPE];
  logic [JW-1:0] r_dt [PIPE];

  logic [AW-1:0] w_ag_a;
  logic [AW-1:0] w_ag_b;
  logic [JW-1:0] w_ag_tw;
  logic [AW-1:0] w_brev;
  logic          w_last_j;
  logic          w_last_s;
  logic          w_fl_end;
  logic          w_last_i;
  logic          w_acc;
  logic          w_unused;

  fft_seq_agu #(.LOG2N(LOG2N)) u_agu (
    .i_s      (r_s),
    .i_j      (r_j),
    .o_addr_a (w_ag_a),
    .o_addr_b (w_ag_b),
    .o_tw     (w_ag_tw)
  );

  // rd_data_b feeds only the external butterfly
  assign w_unused = ^rd_data_b;

  assign w_brev   = AW'(bitrev(12'(r_cnt), LOG2N));
  assign w_last_j = (r_j == JW'(N / 2 - 1));
  assign w_last_s = (r_s == 4'(LOG2N - 1));
  assign w_fl_end = (r_fc == CW'(PIPE - 1));
  assign w_last_i = (r_i == AW'(N - 1));
  assign w_acc    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = COMPUTE;
      COMPUTE: if (w_last_j) w_next = FLUSH;
      FLUSH:   if (w_fl_end) w_next = w_last_s ? DRAIN : COMPUTE;
      DRAIN:   if (w_acc && w_last_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_s   <= '0;
      r_j   <= '0;
      r_fc  <= '0;
      r_i   <= '0;
      r_dw  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load_valid) r_cnt <= r_cnt + AW'(1);
          if (start) begin
            r_s <= '0;
            r_j <= '0;
          end
        end
        COMPUTE: begin
          r_j  <= r_j + JW'(1);
          r_fc <= '0;
        end
        FLUSH: begin
          r_fc <= r_fc + CW'(1);
          if (w_fl_end) begin
            r_s  <= r_s + 4'd1;
            r_j  <= '0;
            r_i  <= '0;
            r_dw <= '0;
          end
        end
        DRAIN: begin
          if (r_dw != CW'(RD_LAT)) r_dw <= r_dw + CW'(1);
          if (w_acc) begin
            r_dw <= '0;
            r_i  <= r_i + AW'(1);
            if (w_last_i) r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Issue-to-write delay line covering RAM read plus butterfly latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PIPE; p++) begin
        r_dv[p] <= 1'b0;
        r_da[p] <= '0;
        r_db[p] <= '0;
        r_dt[p] <= '0;
      end
    end else begin
      r_dv[0] <= (r_state == COMPUTE);
      r_da[0] <= w_ag_a;
      r_db[0] <= w_ag_b;
      r_dt[0] <= w_ag_tw;
      for (int p = 1; p < PIPE; p++) begin
        r_dv[p] <= r_dv[p-1];
        r_da[p] <= r_da[p-1];
        r_db[p] <= r_db[p-1];
        r_dt[p] <= r_dt[p-1];
      end
    end
  end

  always_comb begin
    busy       = (r_state != IDLE);
    load_ready = (r_state == IDLE) && reset_n;
    out_valid  = (r_state == DRAIN) && (r_dw == CW'(RD_LAT));
    done       = (r_state == DRAIN) && w_acc && w_last_i;
    out_data   = (r_state == DRAIN) ? rd_data_a : '0;
    tw_addr    = r_dv[RD_LAT-1] ? r_dt[RD_LAT-1] : '0;
    rd_bank    = 1'b0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    wr_bank    = 1'b0;
    wr_en_a    = 1'b0;
    wr_en_b    = 1'b0;
    wr_addr_a  = '0;
    wr_addr_b  = '0;
    wr_data_a  = '0;
    wr_data_b  = '0;
    unique case (r_state)
      IDLE: begin
        wr_en_a   = load_valid && reset_n;
        wr_addr_a = w_brev;
        wr_data_a = load_data;
      end
      COMPUTE, FLUSH: begin
        if (r_state == COMPUTE) begin
          rd_bank   = r_s[0];
          rd_addr_a = w_ag_a;
          rd_addr_b = w_ag_b;
        end
        wr_bank   = ~r_s[0];
        wr_en_a   = r_dv[PIPE-1];
        wr_en_b   = r_dv[PIPE-1];
        wr_addr_a = r_da[PIPE-1];
        wr_addr_b = r_db[PIPE-1];
        wr_data_a = bf_a_out;
        wr_data_b = bf_b_out;
      end
      DRAIN: begin
        rd_bank   = 1'(LOG2N % 2);
        rd_addr_a = r_i;
      end
      default: ;
    endcase
  end

`ifdef FFT_IFFT_EN
  logic r_inv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_inv <= 1'b0;
    else if (r_state == IDLE && start)    r_inv <= inverse;
  end

  assign twiddle_conj = r_inv;
  assign scale_shift  = r_inv && busy && wr_en_a;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: modular-arithmetic butterfly and RAM models,
// checked against a direct O(N^2) transform; FFT_IFFT_EN ports tied off.
module tb_fft_seq_ctrl;

  localparam int LOG2N  = 3;
  localparam int N      = 1 << LOG2N;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 0;
  localparam int PIPE   = RD_LAT + BF_LAT;
  localparam longint unsigned P  = 65537;
  localparam longint unsigned W8 = 16;

  typedef struct {
    logic [DW-1:0]    d;
    logic [LOG2N-1:0] addr;
  } ld_vec_t;

  logic             clk = 1'b0;
  logic             reset_n, start, busy, done;
  logic             load_valid, load_ready;
  logic [DW-1:0]    load_data;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_data;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0]    rd_data_a, rd_data_b;
  logic [LOG2N-2:0] tw_addr;
  logic [DW-1:0]    bf_a_out, bf_b_out;
  logic             wr_bank, wr_en_a, wr_en_b;
  logic [LOG2N-1:0] wr_addr_a, wr_addr_b;
  logic [DW-1:0]    wr_data_a, wr_data_b;
`ifdef FFT_IFFT_EN
  logic             inverse = 1'b0;
  logic             twiddle_conj, scale_shift;
`endif

  int               n_vec = 0;
  int               n_bad = 0;
  ld_vec_t          ltab [N];
  longint unsigned  wpow [N];
  longint unsigned  xin  [N];
  longint unsigned  xexp [N];
  longint unsigned  bf_t;
  logic [DW-1:0]    mem  [2][N];

  fft_seq_ctrl #(
    .LOG2N(LOG2N), .DW(DW), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .done(done), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .rd_bank(rd_bank),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .tw_addr(tw_addr), .bf_a_out(bf_a_out), .bf_b_out(bf_b_out),
    .wr_bank(wr_bank), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
`ifdef FFT_IFFT_EN
    , .inverse(inverse), .twiddle_conj(twiddle_conj),
    .scale_shift(scale_shift)
`endif
  );

  always #5 clk = ~clk;

  // Two-bank RAM with one cycle of read latency
  always @(posedge clk) begin
    rd_data_a <= mem[rd_bank][rd_addr_a];
    rd_data_b <= mem[rd_bank][rd_addr_b];
    if (wr_en_a) mem[wr_bank][wr_addr_a] <= wr_data_a;
    if (wr_en_b) mem[wr_bank][wr_addr_b] <= wr_data_b;
  end

  // Butterfly over Z_65537 with W = 16 (an 8th root of unity)
  always_comb begin
    bf_t     = (wpow[LOG2N'(tw_addr)] * 64'(rd_data_b)) % P;
    bf_a_out = DW'((64'(rd_data_a) + bf_t) % P);
    bf_b_out = DW'((64'(rd_data_a) + P - bf_t) % P);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int pa(input int s, input int j);
    int h = 1 << s;
    return (j / h) * 2 * h + (j % h);
  endfunction

  function automatic int ptw(input int s, input int j);
    int h = 1 << s;
    return (j % h) * (N / (2 * h));
  endfunction

  task automatic calc_ref();
    for (int m = 0; m < N; m++) begin
      longint unsigned acc = 0;
      for (int n = 0; n < N; n++)
        acc = (acc + xin[n] * wpow[(n * m) % N]) % P;
      xexp[m] = acc;
    end
  endtask

  // Loads xin[], raising start together with the final beat
  task automatic do_load(input bit use_tab, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          load_valid = 1'b0;
          start      = 1'b0;
        end
      end
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = DW'(xin[i]);
      start      = (i == N - 1);
      out_ready  = 1'($urandom_range(0, 1));
      #1;
      if (use_tab) begin
        chk("ld_en", wr_en_a, 1);
        chk("ld_addr", wr_addr_a, ltab[i].addr);
        chk("ld_bank", wr_bank, 0);
      end
    end
    @(negedge clk);
    load_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic chk_sched();
    int cyc;
    cyc = N / 2 + PIPE;
    for (int c = 0; c < LOG2N * cyc; c++) begin
      int s, pos, half;
      s    = c / cyc;
      pos  = c % cyc;
      half = 1 << s;
      if (c > 0) @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("busy", busy, 1);
      chk("ov_cmp", out_valid, 0);
`ifdef FFT_IFFT_EN
      chk("tconj", twiddle_conj, 0);
      chk("sshift", scale_shift, 0);
`endif
      if (pos < N / 2) begin
        chk("rd_a", rd_addr_a, pa(s, pos));
        chk("rd_b", rd_addr_b, pa(s, pos) + half);
        chk("rd_bank", rd_bank, s % 2);
      end
      if (pos >= RD_LAT && pos - RD_LAT < N / 2)
        chk("tw", tw_addr, ptw(s, pos - RD_LAT));
      if (pos >= PIPE) begin
        chk("wr_en_a", wr_en_a, 1);
        chk("wr_en_b", wr_en_b, 1);
        chk("wr_bank", wr_bank, (s + 1) % 2);
        chk("wr_a", wr_addr_a, pa(s, pos - PIPE));
        chk("wr_b", wr_addr_b, pa(s, pos - PIPE) + half);
      end else begin
        chk("wr_idle_a", wr_en_a, 0);
        chk("wr_idle_b", wr_en_b, 0);
      end
    end
    start = 1'b0;
  endtask

  task automatic do_drain(input int stall_beat, input bit rnd);
    int            idx, budget, dones, hold;
    logic [DW-1:0] held;
    idx = 0; budget = 0; dones = 0; hold = 0; held = '0;
    while (idx < N && budget < 400) begin
      @(negedge clk);
      budget++;
      start = 1'($urandom_range(0, 1));
      if (idx == stall_beat && hold > 0) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (idx == stall_beat && hold < 5 && (out_valid || hold > 0)) begin
        if (hold == 0) held = out_data;
        hold++;
        out_ready = 1'b0;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (done) dones++;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, xexp[idx]);
        chk("done_at", done, idx == N - 1);
        idx++;
      end
    end
    chk("drain_beats", idx, N);
    chk("done_cnt", dones, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_ready", load_ready, 1);
    chk("idle_ov", out_valid, 0);
  endtask

  initial begin
    int ba [N];
    ba = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < N; i++) begin
      ltab[i].d    = DW'(i);
      ltab[i].addr = LOG2N'(ba[i]);
    end
    wpow[0] = 1;
    for (int k = 1; k < N; k++) wpow[k] = (wpow[k-1] * W8) % P;

    reset_n    = 1'b0;
    start      = 1'b0;
    load_valid = 1'b1;
    load_data  = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("post_ready", load_ready, 1);
    chk("post_rd_a", rd_addr_a, 0);
    chk("post_tw", tw_addr, 0);

    // Ramp: bit-reversed load, full schedule, stalled drain
    for (int i = 0; i < N; i++) xin[i] = longint'(ltab[i].d);
    calc_ref();
    do_load(1'b1, 1'b0);
    chk_sched();
    do_drain(3, 1'b0);

    // Impulse: every output bin equals the impulse value
    for (int i = 0; i < N; i++) xin[i] = 0;
    xin[0] = 1234;
    for (int i = 0; i < N; i++) xexp[i] = 1234;
    do_load(1'b0, 1'b1);
    do_drain(-1, 1'b1);

    // Abort mid-stage-1
    for (int i = 0; i < N; i++) xin[i] = $urandom_range(0, 65536);
    do_load(1'b0, 1'b0);
    repeat (N / 2 + PIPE + 1) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_a", wr_en_a, 0);
    chk("abort_wr_b", wr_en_b, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Random frames after the abort
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) xin[i] = $urandom_range(0, 65536);
      calc_ref();
      do_load(1'b0, t != 0);
      if (t == 0) chk_sched();
      do_drain((t == 2) ? int'($urandom_range(0, N - 1)) : -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
